// File: rtl/spart_rx_deserializer.sv
// spart_rx_deserializer: 8N1 UART receiver with valid/ready output; define SPART_RX_MAJORITY_EN for 2-of-3 mid-bit voting
module spart_rx_deserializer #(
  parameter int DB_W        = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RX,
  input  logic [DB_W-1:0] db_div,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun,
  output logic            rx_busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0] cnt, db_q;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic rxs, tick, sample;
  assign rxs = sync[SYNC_STAGES-1];
  assign tick = cnt == '0;
  assign rx_busy = state != IDLE;
`ifdef SPART_RX_MAJORITY_EN
  logic v2, v1;
  assign sample = (v2 & v1) | (v2 & rxs) | (v1 & rxs);
`else
  assign sample = rxs;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync      <= '1;
      cnt       <= '0;
      db_q      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], RX};
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= tick ? db_q : cnt - 1'b1;
`ifdef SPART_RX_MAJORITY_EN
      if (cnt == DB_W'(2)) v2 <= rxs;
      if (cnt == DB_W'(1)) v1 <= rxs;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE:  if (!rxs) begin
          state <= START;
          cnt   <= db_div >> 1;
          db_q  <= db_div;
        end
        START: if (tick) begin
          state  <= sample ? IDLE : DATA;
          bitcnt <= '0;
        end
        DATA:  if (tick) begin
          shreg  <= {sample, shreg[7:1]};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == 3'd7) state <= STOP;
        end
        STOP:  if (tick) begin
          if (!sample) begin
            frame_err <= 1'b1;
            state     <= BRK;
          end else begin
            state <= IDLE;
            // a handshake in this same cycle frees the slot for the new byte
            if (rx_valid && !rx_ready) overrun <= 1'b1;
            else begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end
          end
        end
        BRK:   if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spart_rx_deserializer.sv
// tb_spart_rx_deserializer: directed and random UART frames against a queue-based byte model
module tb_spart_rx_deserializer;
  logic clk = 0, rst = 1, RX = 1, rx_ready = 1;
  logic [12:0] db_div = 13'd433;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, rx_busy;
  int checks = 0, failures = 0, cyc = 0;
  int ferr_n = 0, ovr_n = 0, rise_n = 0, rise_cyc = 0, start_cyc = 0;
  logic prev_v = 0;
  logic [7:0] got[$], exp_q[$];

  spart_rx_deserializer dut (
    .clk(clk), .rst(rst), .RX(RX), .db_div(db_div),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (frame_err) ferr_n++;
    if (overrun) ovr_n++;
    if (rx_valid && !prev_v) begin
      rise_n++;
      rise_cyc = cyc;
    end
    prev_v = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input int db, input logic stop_bit, input int nbits);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    db_div = db[12:0];
    for (int i = 0; i < nbits; i++) begin
      RX = f[i];
      if (i == 0) start_cyc = cyc;
      step(db + 1);
    end
  endtask

  task automatic send(input logic [7:0] b, input int db);
    drive_frame(b, db, 1'b1, 10);
  endtask

  task automatic clear();
    got.delete();
    exp_q.delete();
    ferr_n = 0;
    ovr_n = 0;
    rise_n = 0;
  endtask

  function automatic logic [31:0] lat_ok(input int db);
    int l;
    l = 2 + db / 2 + 1 + 9 * (db + 1) + 1;
    return (rise_cyc >= start_cyc + l - 1 && rise_cyc <= start_cyc + l + 1) ? 1 : 0;
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return got.size() > i ? {24'h0, got[i]} : 32'hDEAD;
  endfunction

  initial begin
    int db;
    logic [7:0] b;
    step(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", rx_busy, 0);
    rst = 0;
    step(5);

    clear();
    send(8'hA5, 433);
    step(5);
    chk("t1_count", got.size(), 1);
    chk("t1_byte", got_at(0), 32'hA5);
    chk("t1_rises", rise_n, 1);
    chk("t1_ferr", ferr_n, 0);
    chk("t1_latency", lat_ok(433), 1);

    clear();
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    foreach (exp_q[i]) send(exp_q[i], 97);
    step(5);
    chk("t2_count", got.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_byte", got_at(i), {24'h0, exp_q[i]});
    chk("t2_errs", ferr_n + ovr_n, 0);

    clear();
    send(8'h3C, 2603);
    step(5);
    chk("slow_byte", got_at(0), 32'h3C);
    chk("slow_latency", lat_ok(2603), 1);

    clear();
    rx_ready = 0;
    send(8'h11, 40);
    send(8'h22, 40);
    step(5);
    chk("t3_valid", rx_valid, 1);
    chk("t3_hold", rx_data, 8'h11);
    chk("t3_ovr", ovr_n, 1);
    rx_ready = 1;
    step(3);
    chk("t3_count", got.size(), 1);
    chk("t3_byte", got_at(0), 32'h11);
    chk("t3_drop", rx_valid, 0);

    clear();
    drive_frame(8'h5A, 40, 1'b0, 10);
    step(3 * 41);
    chk("t4_ferr", ferr_n, 1);
    chk("t4_busy_low", rx_busy, 1);
    chk("t4_novalid", rise_n, 0);
    RX = 1;
    step(6);
    chk("t4_idle", rx_busy, 0);
    send(8'h5A, 40);
    step(5);
    chk("t4_count", got.size(), 1);
    chk("t4_byte", got_at(0), 32'h5A);
    chk("t4_ferr_once", ferr_n, 1);

    clear();
    db_div = 13'd80;
    RX = 0;
    step(5);
    chk("t5_busy", rx_busy, 1);
    step(15);
    RX = 1;
    step(3 * 81);
    chk("t5_novalid", rise_n, 0);
    chk("t5_idle", rx_busy, 0);
    chk("t5_ferr", ferr_n, 0);

    clear();
    drive_frame(8'hC3, 60, 1'b1, 5);
    step(30);
    chk("t6_busy", rx_busy, 1);
    RX = 1;
    rst = 1;
    step(1);
    rst = 0;
    chk("t6_valid", rx_valid, 0);
    chk("t6_data", rx_data, 0);
    chk("t6_busy_rst", rx_busy, 0);
    chk("t6_ferr", frame_err, 0);
    step(2 * 61);
    clear();
    send(8'h81, 60);
    step(5);
    chk("t6_count", got.size(), 1);
    chk("t6_byte", got_at(0), 32'h81);

    clear();
    for (int k = 0; k < 16; k++) begin
      db = $urandom_range(15, 120);
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, db);
      step($urandom_range(0, db));
    end
    step(5);
    chk("rnd_count", got.size(), exp_q.size());
    foreach (exp_q[i]) chk("rnd_byte", got_at(i), {24'h0, exp_q[i]});
    chk("rnd_errs", ferr_n + ovr_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
